// File: rtl/uart_in_feeder.sv
// Purpose : console input responder; answers io_uart_in_valid reads from a push-filled character FIFO.
// Latency : read data is combinational in the request cycle; a pushed char is readable 1 cycle later.
// Backpr. : push_ready = !full (registered occupancy only); an empty FIFO answers a read with IDLE_CH.
//
// Ports:
//   clock, reset          sole clock; asynchronous active-low reset
//   push_valid/_ch/_ready valid/ready character push port (bench side)
//   flush                 synchronous clear of FIFO contents (counters kept)
//   io_uart_in_valid/_ch  SoC read request and same-cycle response
//   level                 current occupancy, 0..DEPTH
//   rd_count, miss_count  saturating counts of served reads and idle answers
module uart_in_feeder #(
    parameter int          DEPTH   = 16,
    parameter logic [7:0]  IDLE_CH = 8'hff
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [7:0]                 push_ch,
    output logic                       push_ready,
    input  logic                       flush,
    input  logic                       io_uart_in_valid,
    output logic [7:0]                 io_uart_in_ch,
    output logic [$clog2(DEPTH):0]     level,
    output logic [31:0]                rd_count,
    output logic [31:0]                miss_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    logic empty;
    logic full;
    logic push_acc;
    logic pop;
    logic miss;

    // Status derives from the registered level only: a pop in the same cycle
    // never opens room for a push, and a push into an empty FIFO is never
    // bypassed to a same-cycle read.
    assign empty      = (level == '0);
    assign full       = (level == FULL_LEVEL);
    assign push_ready = !full;

    // A flush cycle drops any offered character, but the read still sees the
    // pre-flush contents and is answered and counted normally.
    assign push_acc = push_valid && !full && !flush;
    assign pop      = io_uart_in_valid && !empty;
    assign miss     = io_uart_in_valid && empty;

    // The head is only presented when a read is actually being served.
    assign io_uart_in_ch = pop ? mem[rptr] : IDLE_CH;

    // Storage carries no reset; stale entries are unreachable once the
    // pointers and level are cleared.
    always_ff @(posedge clock) begin
        if (push_acc) begin
            mem[wptr] <= push_ch;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_acc, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Counters survive flush and stick at all-ones instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_count   <= '0;
            miss_count <= '0;
        end else begin
            if (pop && (rd_count != 32'hffff_ffff)) begin
                rd_count <= rd_count + 32'd1;
            end
            if (miss && (miss_count != 32'hffff_ffff)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_in_feeder.sv
module tb_uart_in_feeder;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        push_valid = 1'b0;
    logic [7:0]  push_ch = 8'h00;
    logic        push_ready;
    logic        flush = 1'b0;
    logic        io_uart_in_valid = 1'b0;
    logic [7:0]  io_uart_in_ch;
    logic [4:0]  level;
    logic [31:0] rd_count;
    logic [31:0] miss_count;

    uart_in_feeder #(.DEPTH(DEPTH), .IDLE_CH(8'hff)) dut (
        .clock            (clock),
        .reset            (reset),
        .push_valid       (push_valid),
        .push_ch          (push_ch),
        .push_ready       (push_ready),
        .flush            (flush),
        .io_uart_in_valid (io_uart_in_valid),
        .io_uart_in_ch    (io_uart_in_ch),
        .level            (level),
        .rd_count         (rd_count),
        .miss_count       (miss_count)
    );

    always #5 clock = ~clock;

    // Reference model: a plain queue of characters plus two counters.
    logic [7:0]  q[$];
    int unsigned m_rd;
    int unsigned m_miss;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] exp_ch(input bit rd);
        if (rd && q.size() > 0) return q[0];
        return 8'hff;
    endfunction

    // Apply inputs shortly after a rising edge and let them settle.
    task automatic drive(input bit pv, input logic [7:0] pc, input bit fl, input bit rd);
        push_valid       = pv;
        push_ch          = pc;
        flush            = fl;
        io_uart_in_valid = rd;
        #1;
    endtask

    // Advance one clock and update the model from the inputs that were applied.
    task automatic tick();
        bit         rd;
        bit         fl;
        bit         pushed;
        logic [7:0] pc;
        rd     = io_uart_in_valid;
        fl     = flush;
        pc     = push_ch;
        pushed = push_valid && (q.size() < DEPTH) && !fl;
        @(posedge clock);
        #1;
        if (rd) begin
            if (q.size() > 0) begin
                void'(q.pop_front());
                m_rd++;
            end else begin
                m_miss++;
            end
        end
        if (fl) q.delete();
        else if (pushed) q.push_back(pc);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
            n_checks += 5;
            if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
            if (push_ready !== 1'b1) begin n_fail++; $display("FAIL reset_push_ready got=%b exp=1", push_ready); end
            if (io_uart_in_ch !== 8'hff) begin n_fail++; $display("FAIL reset_ch got=%h exp=ff", io_uart_in_ch); end
            if (rd_count !== 32'd0) begin n_fail++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
            if (miss_count !== 32'd0) begin n_fail++; $display("FAIL reset_miss_count got=%0d exp=0", miss_count); end
            @(posedge clock);
            #1;
        end
        drive(0, 8'h00, 0, 0);
        reset = 1'b1;
        q.delete();
        m_rd = 0;
        m_miss = 0;
        @(posedge clock);
        #1;
        drive(0, 8'h00, 0, 1);
        n_checks++;
        if (io_uart_in_ch !== 8'hff) begin n_fail++; $display("FAIL post_reset_read got=%h exp=ff", io_uart_in_ch); end
        tick();
        drive(0, 8'h00, 0, 0);
        n_checks++;
        if (miss_count !== 32'd1) begin n_fail++; $display("FAIL post_reset_miss got=%0d exp=1", miss_count); end
    endtask

    task automatic test_order_wrap();
        int          pidx = 0;
        int          ridx = 0;
        int          cyc  = 0;
        int unsigned rd0  = m_rd;
        int unsigned mi0  = m_miss;
        while (ridx < 20 && cyc < 100) begin
            bit rd;
            rd = (cyc % 2) == 1;
            drive(pidx < 20, 8'(8'h41 + pidx), 0, rd);
            if (rd) begin
                n_checks++;
                if (io_uart_in_ch !== 8'(8'h41 + ridx)) begin
                    n_fail++;
                    $display("FAIL order_ch idx=%0d got=%h exp=%h", ridx, io_uart_in_ch, 8'(8'h41 + ridx));
                end
                ridx++;
            end
            if (pidx < 20 && push_ready) pidx++;
            tick();
            cyc++;
        end
        drive(0, 8'h00, 0, 0);
        n_checks += 3;
        if (ridx != 20) begin n_fail++; $display("FAIL order_timeout reads=%0d exp=20", ridx); end
        if (rd_count !== 32'(rd0 + 20)) begin n_fail++; $display("FAIL order_rd_count got=%0d exp=%0d", rd_count, rd0 + 20); end
        if (miss_count !== 32'(mi0)) begin n_fail++; $display("FAIL order_miss got=%0d exp=%0d", miss_count, mi0); end
    endtask

    task automatic test_full();
        logic [7:0] chars[16];
        for (int i = 0; i < 16; i++) begin
            chars[i] = 8'($urandom);
            drive(1, chars[i], 0, 0);
            tick();
        end
        drive(0, 8'h00, 0, 0);
        n_checks += 2;
        if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_push_ready got=%b exp=0", push_ready); end
        if (level !== 5'd16) begin n_fail++; $display("FAIL full_level got=%0d exp=16", level); end
        drive(1, 8'hee, 0, 1);
        n_checks += 2;
        if (io_uart_in_ch !== chars[0]) begin n_fail++; $display("FAIL full_read got=%h exp=%h", io_uart_in_ch, chars[0]); end
        if (push_ready !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle_ready got=%b exp=0", push_ready); end
        tick();
        drive(0, 8'h00, 0, 0);
        n_checks += 2;
        if (level !== 5'd15) begin n_fail++; $display("FAIL full_level_after got=%0d exp=15", level); end
        if (push_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after got=%b exp=1", push_ready); end
        for (int i = 1; i < 16; i++) begin
            drive(0, 8'h00, 0, 1);
            n_checks++;
            if (io_uart_in_ch !== chars[i]) begin n_fail++; $display("FAIL full_drain idx=%0d got=%h exp=%h", i, io_uart_in_ch, chars[i]); end
            tick();
        end
        drive(0, 8'h00, 0, 1);
        n_checks++;
        if (io_uart_in_ch !== 8'hff) begin n_fail++; $display("FAIL full_17th_dropped got=%h exp=ff", io_uart_in_ch); end
        tick();
        drive(0, 8'h00, 0, 0);
    endtask

    task automatic test_empty_push();
        int unsigned mi0 = m_miss;
        drive(1, 8'h41, 0, 1);
        n_checks++;
        if (io_uart_in_ch !== 8'hff) begin n_fail++; $display("FAIL nobypass_ch got=%h exp=ff", io_uart_in_ch); end
        tick();
        drive(0, 8'h00, 0, 1);
        n_checks += 2;
        if (miss_count !== 32'(mi0 + 1)) begin n_fail++; $display("FAIL nobypass_miss got=%0d exp=%0d", miss_count, mi0 + 1); end
        if (io_uart_in_ch !== 8'h41) begin n_fail++; $display("FAIL nobypass_next got=%h exp=41", io_uart_in_ch); end
        tick();
        drive(0, 8'h00, 0, 0);
    endtask

    task automatic test_flush();
        logic [7:0]  head;
        int unsigned rd0 = m_rd;
        head = 8'($urandom);
        for (int i = 0; i < 5; i++) begin
            drive(1, (i == 0) ? head : 8'($urandom), 0, 0);
            tick();
        end
        drive(1, 8'h55, 1, 1);
        n_checks++;
        if (io_uart_in_ch !== head) begin n_fail++; $display("FAIL flush_read got=%h exp=%h", io_uart_in_ch, head); end
        tick();
        drive(0, 8'h00, 0, 1);
        n_checks += 3;
        if (rd_count !== 32'(rd0 + 1)) begin n_fail++; $display("FAIL flush_rd_count got=%0d exp=%0d", rd_count, rd0 + 1); end
        if (level !== 5'd0) begin n_fail++; $display("FAIL flush_level got=%0d exp=0", level); end
        if (io_uart_in_ch !== 8'hff) begin n_fail++; $display("FAIL flush_after_read got=%h exp=ff", io_uart_in_ch); end
        tick();
        drive(0, 8'h00, 0, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 8'($urandom), 0, 0);
            tick();
        end
        drive(0, 8'h00, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        n_checks += 3;
        if (level !== 5'd0) begin n_fail++; $display("FAIL async_level got=%0d exp=0", level); end
        if (push_ready !== 1'b1) begin n_fail++; $display("FAIL async_ready got=%b exp=1", push_ready); end
        if (io_uart_in_ch !== 8'hff) begin n_fail++; $display("FAIL async_ch got=%h exp=ff", io_uart_in_ch); end
        q.delete();
        m_rd = 0;
        m_miss = 0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        drive(0, 8'h00, 0, 1);
        n_checks++;
        if (io_uart_in_ch !== 8'hff) begin n_fail++; $display("FAIL async_post_read got=%h exp=ff", io_uart_in_ch); end
        tick();
        drive(0, 8'h00, 0, 0);
        n_checks++;
        if (miss_count !== 32'd1) begin n_fail++; $display("FAIL async_post_miss got=%0d exp=1", miss_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            bit rd;
            rd = $urandom_range(0, 1);
            drive($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 29) == 0, rd);
            n_checks += 3;
            if (io_uart_in_ch !== exp_ch(rd)) begin n_fail++; $display("FAIL rand_ch cyc=%0d got=%h exp=%h", i, io_uart_in_ch, exp_ch(rd)); end
            if (level !== 5'(q.size())) begin n_fail++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, q.size()); end
            if (push_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, push_ready, q.size() < DEPTH); end
            tick();
        end
        drive(0, 8'h00, 0, 0);
        n_checks += 2;
        if (rd_count !== 32'(m_rd)) begin n_fail++; $display("FAIL rand_rd_count got=%0d exp=%0d", rd_count, m_rd); end
        if (miss_count !== 32'(m_miss)) begin n_fail++; $display("FAIL rand_miss_count got=%0d exp=%0d", miss_count, m_miss); end
    endtask

    initial begin
        #1;
        test_reset();
        test_order_wrap();
        test_full();
        test_empty_push();
        test_flush();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_in_feeder.md
# uart_in_feeder

Simulation-side responder for the SoC console input path: the DUT pulls one character per cycle by asserting `io_uart_in_valid`, and this block answers on `io_uart_in_ch` from an internal FIFO. The FIFO is filled by the testbench (DPI, plusarg script or directed bench) through a valid/ready push port. It sits in the testbench top next to `SimTop` and replaces the constant `8'hff` tie-off on `io_uart_in_ch`. It is the input-side counterpart of the UART output capture logic.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `IDLE_CH`, 8'hff: character returned when a read finds the FIFO empty.
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low (asserted when 0); release synchronous to `clock` by the bench.
- `push_valid`  in  1  bench offers a character.
- `push_ch`  in  8  character offered.
- `push_ready`  out  1  FIFO can accept; equals `!full`.
- `flush`  in  1  synchronous clear of FIFO contents.
- `io_uart_in_valid`  in  1  DUT read request this cycle.
- `io_uart_in_ch`  out  8  response character, same cycle as request.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `rd_count`  out  32  reads served with real data; saturating.
- `miss_count`  out  32  reads answered with `IDLE_CH`; saturating.

## Operation
- Storage: `DEPTH`×8 array, read/write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, occupancy counter `level` (0..DEPTH). `empty = (level==0)`, `full = (level==DEPTH)`.
- Push: accepted when `push_valid && push_ready && !flush`. Write at wptr, wptr+1.
- Read: when `io_uart_in_valid`:
  - not empty: `io_uart_in_ch` = mem[rptr] (combinational), pop at posedge, rptr+1, `rd_count`+1.
  - empty: `io_uart_in_ch = IDLE_CH`, no pointer change, `miss_count`+1.
- When `io_uart_in_valid`=0: `io_uart_in_ch = IDLE_CH`. Head is never consumed without a request.
- Simultaneous push and pop: both occur, `level` unchanged. `push_ready` uses registered `full` only; a pop in the same cycle does not make room for a push while full.
- Push to an empty FIFO in the same cycle as a read: no bypass. The read returns `IDLE_CH` and counts as a miss. The pushed character becomes visible next cycle.
- `flush`: at posedge, rptr=wptr=0 and level=0. A push in the same cycle is dropped (not accepted, `push_ready` still reflects pre-flush `full`). A read in the same cycle is still answered and counted per the pre-flush state. Counters are not cleared.
- Counters saturate at 32'hffff_ffff.

## Timing
- Reset (`reset`=0, async): pointers 0, `level`=0, `rd_count`=0, `miss_count`=0. Outputs: `push_ready`=1, `io_uart_in_ch`=IDLE_CH. Memory contents are not reset.
- Read latency 0 cycles: data is valid combinationally in the request cycle. State updates at the following posedge.
- Push-to-readable latency: 1 cycle.
- Back-to-back reads every cycle drain one entry per cycle in FIFO order.
- Reset asserted mid-stream discards all queued characters immediately. No partial state survives.

## Test plan
- Reset: hold `reset`=0 with random inputs -> `level`=0, `push_ready`=1, `io_uart_in_ch`=8'hff, both counters 0; after release, read -> 8'hff, `miss_count`=1.
- Order and wrap: push 'A'..'T' (20 chars, DEPTH=16) while DUT reads every 2nd cycle -> reads return 'A'..'T' in order, pointers wrap, `rd_count`=20, no misses once data arrives.
- Full: push 16 chars with no reads -> `push_ready`=0, `level`=16. Offer a 17th char with a read in the same cycle -> read returns char 0, 17th not accepted, `level`=15. Next cycle `push_ready`=1.
- Empty with same-cycle push: `level`=0, push 8'h41 and read together -> response 8'hff, `miss_count`+1. Next-cycle read -> 8'h41.
- Flush: 5 queued, assert `flush` with push 8'h55 and read -> read returns head, `rd_count`+1, 8'h55 dropped. Next cycle `level`=0 and a read -> 8'hff.
- Async reset mid-run: 8 queued, drop `reset` between edges -> `level`=0 immediately. After release, a read returns 8'hff.
